// File: rtl/fp_div_arbiter_if.sv
// Bundle of requester, response and divider-side signals for fp_div_arbiter.
// The arbiter uses the slave view; whatever surrounds it (requesters plus divider) uses master.
interface fp_div_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [32*NUM_REQ-1:0] req_a_i;
    logic [32*NUM_REQ-1:0] req_b_i;

    logic [NUM_REQ-1:0]    rsp_valid_o;
    logic [NUM_REQ-1:0]    rsp_ready_i;
    logic [31:0]           rsp_data_o;
    logic [4:0]            rsp_flags_o;

    logic                  div_start_o;
    logic [31:0]           div_a_o;
    logic [31:0]           div_b_o;
    logic                  div_ready_i;
    logic                  div_done_i;
    logic [31:0]           div_s_i;
    logic                  div_error_i;
    logic                  div_inf_i;
    logic                  div_nan_i;
    logic                  div_zero_i;

    logic                  busy_o;
    logic [OW-1:0]         owner_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
        input  div_ready_i, div_done_i, div_s_i,
        input  div_error_i, div_inf_i, div_nan_i, div_zero_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_flags_o,
        output div_start_o, div_a_o, div_b_o, busy_o, owner_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
        output div_ready_i, div_done_i, div_s_i,
        output div_error_i, div_inf_i, div_nan_i, div_zero_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_flags_o,
        input  div_start_o, div_a_o, div_b_o, busy_o, owner_o
    );
endinterface

// File: rtl/fp_div_arbiter.sv
// Round-robin sharing of one iterative FP32 divider among NUM_REQ requesters,
// with a watchdog that substitutes a NaN result if the divider never reports Done.
module fp_div_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    fp_div_arbiter_if.slave bus
);
    localparam int          OW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] rr_q, rr_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   data_q, data_d;
    logic [4:0]    flags_q, flags_d;
    logic [15:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic               div_start;

    logic [OW-1:0]      cand_idx [NUM_REQ];
    logic [31:0]        a_arr    [NUM_REQ];
    logic [31:0]        b_arr    [NUM_REQ];
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] owner_onehot;
    logic [OW-1:0]      win;
    logic               win_found;

    // cand_idx[gi] is the requester examined at search position gi, starting just after rr.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign cand_idx[gi]     = OW'((int'(rr_q) + 1 + gi) % NUM_REQ);
            assign a_arr[gi]        = bus.req_a_i[32*gi +: 32];
            assign b_arr[gi]        = bus.req_b_i[32*gi +: 32];
            assign win_onehot[gi]   = win_found && (win == OW'(gi));
            assign owner_onehot[gi] = (owner_q == OW'(gi));
        end
    endgenerate

    // Walk the search order backwards so the earliest valid candidate is the last assignment.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid_i[cand_idx[i]]) begin
                win       = cand_idx[i];
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        rsp_valid = '0;
        div_start = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req_ready = win_onehot;
                if (win_found) begin
                    a_d     = a_arr[win];
                    b_d     = b_arr[win];
                    owner_d = win;
                    rr_d    = win;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.div_ready_i) begin
                    div_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // Expiry is judged on the post-increment count, so RESP opens TIMEOUT_CYCLES after start.
                cnt_d = cnt_q + 16'd1;
                if (bus.div_done_i) begin
                    data_d  = bus.div_s_i;
                    flags_d = {1'b0, bus.div_error_i, bus.div_inf_i, bus.div_nan_i, bus.div_zero_i};
                    state_d = S_RESP;
                end else if ({1'b0, cnt_d} >= TO_LAST) begin
                    data_d  = QNAN;
                    flags_d = 5'b11010;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = owner_onehot;
                if (|(bus.rsp_ready_i & owner_onehot)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rr_q    <= OW'(NUM_REQ - 1);
            owner_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_data_o  = data_q;
    assign bus.rsp_flags_o = flags_q;
    assign bus.div_start_o = div_start;
    assign bus.div_a_o     = a_q;
    assign bus.div_b_o     = b_q;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.owner_o     = owner_q;
endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter (2 requesters, 8-cycle watchdog); the bench plays
// both requesters and the divider and checks every step against hand-computed values.
module tb_fp_div_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fp_div_arbiter_if #(.NUM_REQ(2)) bus ();

    fp_div_arbiter #(
        .NUM_REQ       (2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
        bus.req_a_i[32*k +: 32] = a;
        bus.req_b_i[32*k +: 32] = b;
    endtask

    // Drive a one-cycle Done from the divider; f = {error, inf, nan, zero}.
    task automatic pulse_done(input logic [31:0] s, input logic [3:0] f);
        bus.div_done_i  = 1'b1;
        bus.div_s_i     = s;
        bus.div_error_i = f[3];
        bus.div_inf_i   = f[2];
        bus.div_nan_i   = f[1];
        bus.div_zero_i  = f[0];
        cyc();
        bus.div_done_i  = 1'b0;
        bus.div_s_i     = '0;
        bus.div_error_i = 1'b0;
        bus.div_inf_i   = 1'b0;
        bus.div_nan_i   = 1'b0;
        bus.div_zero_i  = 1'b0;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        bus.req_valid_i = '0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        bus.rsp_ready_i = '0;
        bus.div_ready_i = 1'b1;
        bus.div_done_i  = 1'b0;
        bus.div_s_i     = '0;
        bus.div_error_i = 1'b0;
        bus.div_inf_i   = 1'b0;
        bus.div_nan_i   = 1'b0;
        bus.div_zero_i  = 1'b0;
        cyc();
        cyc();

        // Reset state
        chk("rst_req_ready", 32'(bus.req_ready_o), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        chk("rst_div_start", 32'(bus.div_start_o), 32'h0);
        chk("rst_busy",      32'(bus.busy_o),      32'h0);
        chk("rst_div_a",     bus.div_a_o,          32'h0);
        chk("rst_div_b",     bus.div_b_o,          32'h0);
        chk("rst_rsp_data",  bus.rsp_data_o,       32'h0);
        chk("rst_rsp_flags", 32'(bus.rsp_flags_o), 32'h0);
        chk("rst_owner",     32'(bus.owner_o),     32'h0);
        rst = 1'b0;

        // Single request: 6.0 / 3.0, divider latency 1
        set_req(0, 32'h40C0_0000, 32'h4040_0000);
        bus.req_valid_i = 2'b01;
        settle();
        chk("t1_req_ready", 32'(bus.req_ready_o), 32'h1);
        cyc();
        bus.req_valid_i = 2'b00;
        chk("t1_start",     32'(bus.div_start_o), 32'h1);
        chk("t1_div_a",     bus.div_a_o,          32'h40C0_0000);
        chk("t1_div_b",     bus.div_b_o,          32'h4040_0000);
        chk("t1_owner",     32'(bus.owner_o),     32'h0);
        chk("t1_busy",      32'(bus.busy_o),      32'h1);
        cyc();
        chk("t1_start_once", 32'(bus.div_start_o), 32'h0);
        chk("t1_no_early_rsp", 32'(bus.rsp_valid_o), 32'h0);
        pulse_done(32'h4000_0000, 4'b0000);
        chk("t1_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
        chk("t1_rsp_data",  bus.rsp_data_o,       32'h4000_0000);
        chk("t1_rsp_flags", 32'(bus.rsp_flags_o), 32'h0);
        bus.rsp_ready_i = 2'b01;
        cyc();
        bus.rsp_ready_i = 2'b00;
        chk("t1_idle_busy", 32'(bus.busy_o),      32'h0);
        chk("t1_idle_rsp",  32'(bus.rsp_valid_o), 32'h0);

        // Contention from reset: req 0 first, then req 1, then req 0 again
        set_req(0, 32'h40A0_0000, 32'h4000_0000);
        set_req(1, 32'h3F80_0000, 32'h4180_0000);
        bus.req_valid_i = 2'b11;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        chk("t2_grant0", 32'(bus.req_ready_o), 32'h1);
        cyc();
        chk("t2_div_a0", bus.div_a_o, 32'h40A0_0000);
        cyc();
        pulse_done(32'h4020_0000, 4'b0000);
        chk("t2_rsp0_valid", 32'(bus.rsp_valid_o), 32'h1);
        chk("t2_rsp0_data",  bus.rsp_data_o,       32'h4020_0000);
        bus.rsp_ready_i = 2'b10;
        cyc();
        chk("t2_foreign_ready_ignored", 32'(bus.rsp_valid_o), 32'h1);
        bus.rsp_ready_i = 2'b01;
        cyc();
        bus.rsp_ready_i = 2'b00;
        settle();
        chk("t2_grant1", 32'(bus.req_ready_o), 32'h2);
        cyc();
        chk("t2_owner1", 32'(bus.owner_o), 32'h1);
        chk("t2_div_a1", bus.div_a_o,      32'h3F80_0000);
        chk("t2_div_b1", bus.div_b_o,      32'h4180_0000);
        cyc();
        pulse_done(32'h3D80_0000, 4'b0000);
        chk("t2_rsp1_valid", 32'(bus.rsp_valid_o), 32'h2);
        chk("t2_rsp1_data",  bus.rsp_data_o,       32'h3D80_0000);
        bus.rsp_ready_i = 2'b10;
        cyc();
        bus.rsp_ready_i = 2'b00;
        settle();
        chk("t2_grant0_again", 32'(bus.req_ready_o), 32'h1);
        cyc();
        bus.req_valid_i = 2'b00;
        chk("t2_owner0_again", 32'(bus.owner_o), 32'h0);
        cyc();
        pulse_done(32'h4020_0000, 4'b0000);
        bus.rsp_ready_i = 2'b01;
        cyc();
        bus.rsp_ready_i = 2'b00;

        // Exception flags pass through: x / 0 with inf reported
        set_req(0, 32'h4018_0000, 32'h0000_0000);
        bus.req_valid_i = 2'b01;
        cyc();
        bus.req_valid_i = 2'b00;
        chk("t3_div_a", bus.div_a_o, 32'h4018_0000);
        chk("t3_div_b", bus.div_b_o, 32'h0000_0000);
        cyc();
        pulse_done(32'h7F80_0000, 4'b0100);
        chk("t3_rsp_flags", 32'(bus.rsp_flags_o), 32'h04);
        chk("t3_rsp_data",  bus.rsp_data_o,       32'h7F80_0000);
        bus.rsp_ready_i = 2'b01;
        cyc();
        bus.rsp_ready_i = 2'b00;

        // Watchdog: no Done, response exactly 8 cycles after the start pulse
        set_req(1, 32'h3F80_0000, 32'h4000_0000);
        bus.req_valid_i = 2'b10;
        cyc();
        bus.req_valid_i = 2'b00;
        chk("t4_start", 32'(bus.div_start_o), 32'h1);
        cyc();
        for (int i = 1; i <= 7; i++) begin
            chk($sformatf("t4_no_rsp_c%0d", i), 32'(bus.rsp_valid_o), 32'h0);
            cyc();
        end
        chk("t4_rsp_valid", 32'(bus.rsp_valid_o), 32'h2);
        chk("t4_rsp_data",  bus.rsp_data_o,       32'h7FC0_0000);
        chk("t4_rsp_flags", 32'(bus.rsp_flags_o), 32'h1A);
        pulse_done(32'hDEAD_BEEF, 4'b1111);
        chk("t4_late_done_data",  bus.rsp_data_o,       32'h7FC0_0000);
        chk("t4_late_done_flags", 32'(bus.rsp_flags_o), 32'h1A);
        bus.rsp_ready_i = 2'b10;
        cyc();
        bus.rsp_ready_i = 2'b00;
        bus.div_done_i  = 1'b1;
        bus.div_s_i     = 32'hDEAD_BEEF;
        set_req(0, 32'h3F80_0000, 32'h3F80_0000);
        bus.req_valid_i = 2'b01;
        cyc();
        bus.div_done_i  = 1'b0;
        bus.div_s_i     = '0;
        bus.req_valid_i = 2'b00;
        cyc();
        pulse_done(32'h3F80_0000, 4'b0000);
        chk("t4_next_rsp_data",  bus.rsp_data_o,       32'h3F80_0000);
        chk("t4_next_rsp_flags", 32'(bus.rsp_flags_o), 32'h0);
        bus.rsp_ready_i = 2'b01;
        cyc();
        bus.rsp_ready_i = 2'b00;

        // Backpressure: divider busy for 5 cycles, consumer stalls for 4
        bus.div_ready_i = 1'b0;
        set_req(0, 32'h4120_0000, 32'h4000_0000);
        bus.req_valid_i = 2'b01;
        cyc();
        set_req(1, 32'h4000_0000, 32'h3F80_0000);
        bus.req_valid_i = 2'b11;
        settle();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5_no_start_c%0d", i), 32'(bus.div_start_o), 32'h0);
            chk($sformatf("t5_no_grant_c%0d", i), 32'(bus.req_ready_o), 32'h0);
            cyc();
        end
        bus.div_ready_i = 1'b1;
        settle();
        chk("t5_start", 32'(bus.div_start_o), 32'h1);
        cyc();
        pulse_done(32'h40A0_0000, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_hold_valid_c%0d", i), 32'(bus.rsp_valid_o), 32'h1);
            chk($sformatf("t5_hold_data_c%0d", i),  bus.rsp_data_o,       32'h40A0_0000);
            chk($sformatf("t5_hold_flags_c%0d", i), 32'(bus.rsp_flags_o), 32'h01);
            chk($sformatf("t5_hold_nogrant_c%0d", i), 32'(bus.req_ready_o), 32'h0);
            cyc();
        end
        bus.rsp_ready_i = 2'b01;
        cyc();
        bus.rsp_ready_i = 2'b00;
        settle();
        chk("t5_grant_after_hs", 32'(bus.req_ready_o), 32'h2);
        bus.req_valid_i = 2'b00;
        cyc();

        // Reset in the middle of WAIT
        set_req(0, 32'h4080_0000, 32'h4000_0000);
        bus.req_valid_i = 2'b01;
        cyc();
        bus.req_valid_i = 2'b00;
        cyc();
        cyc();
        chk("t6_busy_before_rst", 32'(bus.busy_o), 32'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        chk("t6_busy",      32'(bus.busy_o),      32'h0);
        chk("t6_div_start", 32'(bus.div_start_o), 32'h0);
        chk("t6_div_a",     bus.div_a_o,          32'h0);
        chk("t6_div_b",     bus.div_b_o,          32'h0);
        chk("t6_rsp_data",  bus.rsp_data_o,       32'h0);
        chk("t6_rsp_flags", 32'(bus.rsp_flags_o), 32'h0);
        chk("t6_owner",     32'(bus.owner_o),     32'h0);
        pulse_done(32'hDEAD_BEEF, 4'b1111);
        chk("t6_stale_done_busy", 32'(bus.busy_o),      32'h0);
        chk("t6_stale_done_rsp",  32'(bus.rsp_valid_o), 32'h0);
        bus.req_valid_i = 2'b01;
        cyc();
        bus.req_valid_i = 2'b00;
        chk("t6_fresh_div_a", bus.div_a_o, 32'h4080_0000);
        cyc();
        pulse_done(32'h4000_0000, 4'b0000);
        chk("t6_fresh_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
        chk("t6_fresh_rsp_data",  bus.rsp_data_o,       32'h4000_0000);
        bus.rsp_ready_i = 2'b01;
        cyc();
        bus.rsp_ready_i = 2'b00;
        chk("t6_fresh_done", 32'(bus.busy_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
